// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that lets several byte-stream
// requesters share one UART transmitter. A requester keeps the grant for
// a whole packet (until a byte marked last is sent). A holder that goes
// quiet mid-packet loses the grant after HOLD_TIMEOUT idle cycles.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int HOLD_TIMEOUT = 255
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic                 tx_isNew,
  output logic [7:0]           tx_message,
  input  logic                 tx_ready,
  output logic [2:0]           grant_id,
  output logic                 busy,
  output logic                 timeout_pulse
);

  localparam logic [3:0] NUM_REQ_W     = 4'(NUM_REQ);
  localparam logic [7:0] TIMEOUT_LIMIT = 8'(HOLD_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GRANT     = 3'd1,
    S_LOAD      = 3'd2,
    S_WAIT_LOW  = 3'd3,
    S_WAIT_HIGH = 3'd4,
    S_HOLD      = 3'd5
  } state_t;

  state_t      state, state_n;
  logic [2:0]  grant_q, grant_n;
  logic [2:0]  rr_ptr, rr_n;
  logic [7:0]  byte_q, byte_n;
  logic        last_q, last_n;
  logic        pkt_open, open_n;
  logic [7:0]  hold_cnt, cnt_n;
  logic        timeout_q, timeout_n;

  logic        holder_valid;
  logic        holder_last;
  logic [7:0]  holder_data;
  logic [2:0]  rr_winner;
  logic        rr_found;
  logic [3:0]  rr_sum;
  logic [3:0]  rr_idx;
  logic [3:0]  ptr_sum;
  logic [2:0]  next_ptr;
  logic [7:0]  cnt_inc;

  // Select the current holder's inputs and raise its ack while in GRANT.
  always_comb begin
    holder_valid = 1'b0;
    holder_last  = 1'b0;
    holder_data  = 8'd0;
    req_ack      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == 3'(i)) begin
        holder_valid = req_valid[i];
        holder_last  = req_last[i];
        holder_data  = req_data[8*i +: 8];
      end else begin
        holder_valid = holder_valid;
      end
      req_ack[i] = (state == S_GRANT) && (grant_q == 3'(i)) && req_valid[i];
    end
  end

  // Round-robin search: first valid requester starting at rr_ptr, wrapping.
  always_comb begin
    rr_winner = 3'd0;
    rr_found  = 1'b0;
    rr_sum    = 4'd0;
    rr_idx    = 4'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_sum = {1'b0, rr_ptr} + 4'(k);
      rr_idx = (rr_sum >= NUM_REQ_W) ? (rr_sum - NUM_REQ_W) : rr_sum;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!rr_found && (rr_idx == 4'(i)) && req_valid[i]) begin
          rr_winner = 3'(i);
          rr_found  = 1'b1;
        end else begin
          rr_found  = rr_found;
        end
      end
    end
  end

  // Pointer one past the holder, and the incremented hold counter.
  always_comb begin
    ptr_sum  = {1'b0, grant_q} + 4'd1;
    next_ptr = (ptr_sum >= NUM_REQ_W) ? 3'd0 : ptr_sum[2:0];
    cnt_inc  = hold_cnt + 8'd1;
  end

  // Next-state and next-register logic; every register holds by default.
  always_comb begin
    state_n   = state;
    grant_n   = grant_q;
    rr_n      = rr_ptr;
    byte_n    = byte_q;
    last_n    = last_q;
    open_n    = pkt_open;
    cnt_n     = hold_cnt;
    timeout_n = 1'b0;
    case (state)
      S_IDLE: begin
        if (tx_ready && (|req_valid)) begin
          grant_n = rr_winner;
          state_n = S_GRANT;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_GRANT: begin
        if (holder_valid) begin
          byte_n  = holder_data;
          last_n  = holder_last;
          state_n = S_LOAD;
        end else if (pkt_open) begin
          state_n = S_HOLD;
        end else begin
          state_n = S_IDLE;
        end
      end
      S_LOAD: begin
        state_n = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        // Wait for the transmitter to take the byte before looking for done.
        if (!tx_ready) begin
          state_n = S_WAIT_HIGH;
        end else begin
          state_n = S_WAIT_LOW;
        end
      end
      S_WAIT_HIGH: begin
        if (tx_ready) begin
          if (last_q) begin
            open_n  = 1'b0;
            rr_n    = next_ptr;
            state_n = S_IDLE;
          end else begin
            open_n  = 1'b1;
            state_n = S_HOLD;
          end
        end else begin
          state_n = S_WAIT_HIGH;
        end
      end
      S_HOLD: begin
        if (holder_valid) begin
          cnt_n   = 8'd0;
          state_n = S_GRANT;
        end else if (cnt_inc == TIMEOUT_LIMIT) begin
          cnt_n     = 8'd0;
          timeout_n = 1'b1;
          open_n    = 1'b0;
          rr_n      = next_ptr;
          state_n   = S_IDLE;
        end else begin
          cnt_n   = cnt_inc;
          state_n = S_HOLD;
        end
      end
      default: begin
        state_n = S_IDLE;
        open_n  = 1'b0;
        cnt_n   = 8'd0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Grant, pointer, captured byte, packet and timeout registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      grant_q   <= 3'd0;
      rr_ptr    <= 3'd0;
      byte_q    <= 8'd0;
      last_q    <= 1'b0;
      pkt_open  <= 1'b0;
      hold_cnt  <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      grant_q   <= grant_n;
      rr_ptr    <= rr_n;
      byte_q    <= byte_n;
      last_q    <= last_n;
      pkt_open  <= open_n;
      hold_cnt  <= cnt_n;
      timeout_q <= timeout_n;
    end
  end

  assign tx_isNew      = (state == S_LOAD);
  assign tx_message    = byte_q;
  assign grant_id      = grant_q;
  assign busy          = (state != S_IDLE);
  assign timeout_pulse = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed testbench for uart_tx_arbiter: per-requester byte queues and a
// simple transmitter model drive the DUT; each scenario task checks its
// own hand-computed expectations.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int HT = 255;

  logic            clock;
  logic            reset_n;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ack;
  logic            tx_isNew;
  logic [7:0]      tx_message;
  logic            tx_ready;
  logic [2:0]      grant_id;
  logic            busy;
  logic            timeout_pulse;

  uart_tx_arbiter #(.NUM_REQ(NR), .HOLD_TIMEOUT(HT)) dut (
    .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ack(req_ack), .tx_isNew(tx_isNew), .tx_message(tx_message),
    .tx_ready(tx_ready), .grant_id(grant_id), .busy(busy), .timeout_pulse(timeout_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // requester queues: {last, data}
  logic [8:0]  rq_mem [NR][8];
  int          rq_head [NR];
  int          rq_tail [NR];
  logic [NR-1:0] hold_off;

  // transmitter model
  int tx_len;
  int tx_left;

  // samples and logs
  int          cyc;
  logic [NR-1:0] s_ack;
  logic        s_new, s_busy, s_to, prev_new;
  logic [7:0]  s_msg;
  logic [2:0]  s_grant;
  logic [7:0]  tx_log [64];
  int          tx_n;
  int          ack_log [64];
  int          ack_n;
  int          to_n, to_cyc, rise_cyc;
  logic        multi_ack, dbl_new;

  task automatic push(input int r, input logic [7:0] d, input logic l);
    rq_mem[r][rq_tail[r]] = {l, d};
    rq_tail[r]++;
  endtask

  task automatic drive_reqs();
    for (int i = 0; i < NR; i++) begin
      if ((rq_head[i] != rq_tail[i]) && !hold_off[i]) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = rq_mem[i][rq_head[i]][7:0];
        req_last[i]        = rq_mem[i][rq_head[i]][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NR; i++) begin
      rq_head[i] = 0;
      rq_tail[i] = 0;
    end
    hold_off  = '0;
    tx_ready  = 1'b1;
    tx_left   = 0;
    tx_len    = 3;
    tx_n      = 0;
    ack_n     = 0;
    to_n      = 0;
    to_cyc    = 0;
    rise_cyc  = 0;
    multi_ack = 1'b0;
    dbl_new   = 1'b0;
    prev_new  = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_model();
    drive_reqs();
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  // one clock: sample at negedge, then update requesters and transmitter after posedge
  task automatic tick();
    @(negedge clock);
    cyc++;
    s_ack   = req_ack;
    s_new   = tx_isNew;
    s_msg   = tx_message;
    s_busy  = busy;
    s_grant = grant_id;
    s_to    = timeout_pulse;
    if ($countones(s_ack) > 1) multi_ack = 1'b1;
    if (s_new && prev_new) dbl_new = 1'b1;
    prev_new = s_new;
    if (s_new) begin
      if (tx_n < 64) tx_log[tx_n] = s_msg;
      tx_n++;
    end
    for (int i = 0; i < NR; i++) begin
      if (s_ack[i]) begin
        if (ack_n < 64) ack_log[ack_n] = i;
        ack_n++;
      end
    end
    if (s_to) begin
      to_n++;
      to_cyc = cyc;
    end
    @(posedge clock);
    #1;
    for (int i = 0; i < NR; i++) if (s_ack[i]) rq_head[i]++;
    if (s_new) begin
      tx_ready = 1'b0;
      tx_left  = tx_len;
    end else if (tx_left > 0) begin
      tx_left--;
      if (tx_left == 0) begin
        tx_ready = 1'b1;
        rise_cyc = cyc;
      end
    end
    drive_reqs();
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    req_valid = '1;
    req_last  = '1;
    req_data  = 32'hDEADBEEF;
    tx_ready  = 1'b1;
    repeat (3) @(posedge clock);
    #2;
    checks++; if (req_ack !== 4'b0000) begin failures++; $display("FAIL reset_ack: got %b expected 0000", req_ack); end
    checks++; if (tx_isNew !== 1'b0) begin failures++; $display("FAIL reset_isnew: got %b expected 0", tx_isNew); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (timeout_pulse !== 1'b0) begin failures++; $display("FAIL reset_timeout: got %b expected 0", timeout_pulse); end
    checks++; if (tx_message !== 8'h00) begin failures++; $display("FAIL reset_msg: got %h expected 00", tx_message); end
    checks++; if (grant_id !== 3'd0) begin failures++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
  endtask

  task automatic test_latency();
    do_reset();
    push(0, 8'h5A, 1'b1);
    drive_reqs();
    tick();
    checks++; if (s_ack !== 4'b0000) begin failures++; $display("FAIL lat_t_ack: got %b expected 0000", s_ack); end
    tick();
    checks++; if (s_ack !== 4'b0001) begin failures++; $display("FAIL lat_t1_ack: got %b expected 0001", s_ack); end
    checks++; if (s_new !== 1'b0) begin failures++; $display("FAIL lat_t1_isnew: got %b expected 0", s_new); end
    checks++; if (s_busy !== 1'b1) begin failures++; $display("FAIL lat_t1_busy: got %b expected 1", s_busy); end
    tick();
    checks++; if (s_new !== 1'b1) begin failures++; $display("FAIL lat_t2_isnew: got %b expected 1", s_new); end
    checks++; if (s_msg !== 8'h5A) begin failures++; $display("FAIL lat_t2_msg: got %h expected 5a", s_msg); end
    checks++; if (s_ack !== 4'b0000) begin failures++; $display("FAIL lat_t2_ack: got %b expected 0000", s_ack); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_tx [5];
    int         exp_ack [5];
    exp_tx  = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h11};
    exp_ack = '{0, 1, 2, 3, 0};
    do_reset();
    push(0, 8'h10, 1'b1); push(0, 8'h11, 1'b1);
    push(1, 8'h20, 1'b1); push(2, 8'h30, 1'b1); push(3, 8'h40, 1'b1);
    drive_reqs();
    for (int k = 0; k < 200 && tx_n < 5; k++) tick();
    repeat (20) tick();
    checks++; if (tx_n !== 5) begin failures++; $display("FAIL rr_tx_count: got %0d expected 5", tx_n); end
    checks++; if (ack_n !== 5) begin failures++; $display("FAIL rr_ack_count: got %0d expected 5", ack_n); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (tx_log[k] !== exp_tx[k]) begin failures++; $display("FAIL rr_byte%0d: got %h expected %h", k, tx_log[k], exp_tx[k]); end
      checks++; if (ack_log[k] !== exp_ack[k]) begin failures++; $display("FAIL rr_grant%0d: got %0d expected %0d", k, ack_log[k], exp_ack[k]); end
    end
    checks++; if (multi_ack !== 1'b0) begin failures++; $display("FAIL rr_onehot_ack: got %b expected 0", multi_ack); end
    checks++; if (dbl_new !== 1'b0) begin failures++; $display("FAIL rr_isnew_b2b: got %b expected 0", dbl_new); end
  endtask

  task automatic test_packet();
    logic [7:0] exp_tx [5];
    int         exp_ack [5];
    exp_tx  = '{8'hA1, 8'hA2, 8'hA3, 8'h3C, 8'h0A};
    exp_ack = '{2, 2, 2, 3, 0};
    do_reset();
    push(0, 8'h0A, 1'b1);
    push(2, 8'hA1, 1'b0); push(2, 8'hA2, 1'b0); push(2, 8'hA3, 1'b1);
    push(3, 8'h3C, 1'b1);
    hold_off = 4'b1001;
    drive_reqs();
    for (int k = 0; k < 20 && ack_n < 1; k++) tick();
    hold_off = 4'b0000;
    drive_reqs();
    for (int k = 0; k < 200 && tx_n < 5; k++) tick();
    repeat (10) tick();
    checks++; if (tx_n !== 5) begin failures++; $display("FAIL pkt_tx_count: got %0d expected 5", tx_n); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (tx_log[k] !== exp_tx[k]) begin failures++; $display("FAIL pkt_byte%0d: got %h expected %h", k, tx_log[k], exp_tx[k]); end
      checks++; if (ack_log[k] !== exp_ack[k]) begin failures++; $display("FAIL pkt_grant%0d: got %0d expected %0d", k, ack_log[k], exp_ack[k]); end
    end
  endtask

  task automatic test_timeout();
    int d;
    do_reset();
    push(1, 8'h51, 1'b0);
    push(2, 8'h61, 1'b1);
    drive_reqs();
    for (int k = 0; k < 20 && tx_n < 1; k++) tick();
    for (int k = 0; k < 400 && to_n < 1; k++) tick();
    d = to_cyc - rise_cyc;
    checks++; if (to_n !== 1) begin failures++; $display("FAIL to_seen: got %0d expected 1", to_n); end
    checks++; if (d !== HT + 2) begin failures++; $display("FAIL to_delay: got %0d expected %0d", d, HT + 2); end
    checks++; if (ack_n !== 1) begin failures++; $display("FAIL to_hold_ignores: got %0d acks expected 1", ack_n); end
    tick();
    checks++; if (s_to !== 1'b0) begin failures++; $display("FAIL to_one_cycle: got %b expected 0", s_to); end
    checks++; if (s_ack !== 4'b0100) begin failures++; $display("FAIL to_next_grant: got %b expected 0100", s_ack); end
    for (int k = 0; k < 20 && tx_n < 2; k++) tick();
    checks++; if (tx_log[1] !== 8'h61) begin failures++; $display("FAIL to_next_byte: got %h expected 61", tx_log[1]); end
  endtask

  task automatic test_stall();
    int bad_ack;
    int bad_busy;
    do_reset();
    tx_len = 50;
    push(0, 8'h77, 1'b1);
    push(1, 8'h88, 1'b1);
    drive_reqs();
    for (int k = 0; k < 20 && tx_n < 1; k++) tick();
    bad_ack  = 0;
    bad_busy = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (s_ack !== 4'b0000) bad_ack++;
      if (s_busy !== 1'b1) bad_busy++;
    end
    checks++; if (bad_ack !== 0) begin failures++; $display("FAIL stall_no_ack: got %0d ack cycles expected 0", bad_ack); end
    checks++; if (bad_busy !== 0) begin failures++; $display("FAIL stall_busy: got %0d idle cycles expected 0", bad_busy); end
    checks++; if (tx_n !== 1) begin failures++; $display("FAIL stall_no_load: got %0d loads expected 1", tx_n); end
    for (int k = 0; k < 40 && tx_n < 2; k++) tick();
    checks++; if (tx_log[1] !== 8'h88) begin failures++; $display("FAIL stall_resume: got %h expected 88", tx_log[1]); end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    push(1, 8'h91, 1'b0);
    push(1, 8'h92, 1'b1);
    push(3, 8'hB3, 1'b1);
    hold_off = 4'b1000;
    drive_reqs();
    for (int k = 0; k < 20 && tx_n < 1; k++) tick();
    tick();
    tick();
    checks++; if (s_busy !== 1'b1) begin failures++; $display("FAIL mid_busy_before: got %b expected 1", s_busy); end
    reset_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy: got %b expected 0", busy); end
    checks++; if (grant_id !== 3'd0) begin failures++; $display("FAIL mid_grant: got %0d expected 0", grant_id); end
    checks++; if (tx_message !== 8'h00) begin failures++; $display("FAIL mid_msg: got %h expected 00", tx_message); end
    checks++; if (req_ack !== 4'b0000) begin failures++; $display("FAIL mid_ack: got %b expected 0000", req_ack); end
    hold_off = 4'b0010;
    tx_ready = 1'b1;
    tx_left  = 0;
    tx_n     = 0;
    ack_n    = 0;
    drive_reqs();
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    for (int k = 0; k < 20 && tx_n < 1; k++) tick();
    repeat (20) tick();
    checks++; if (ack_n !== 1) begin failures++; $display("FAIL mid_ack_count: got %0d expected 1", ack_n); end
    checks++; if (ack_log[0] !== 3) begin failures++; $display("FAIL mid_regrant: got %0d expected 3", ack_log[0]); end
    checks++; if (tx_n !== 1) begin failures++; $display("FAIL mid_tx_count: got %0d expected 1", tx_n); end
    checks++; if (tx_log[0] !== 8'hB3) begin failures++; $display("FAIL mid_byte: got %h expected b3", tx_log[0]); end
  endtask

  initial begin
    cyc       = 0;
    reset_n   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_ready  = 1'b1;
    clear_model();
    test_reset();
    test_latency();
    test_round_robin();
    test_packet();
    test_timeout();
    test_stall();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
